// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one fixed-latency single-port RAM between instruction fetch and load/store, halting the core for each step
module core_mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 14
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              HLTI,
    input  logic [31:0]       IADDR,
    output logic [31:0]       IDATA,
    input  logic [31:0]       DADDR,
    input  logic [31:0]       DATAO,
    output logic [31:0]       DATAI,
    input  logic [3:0]        BE,
    input  logic              WR,
    input  logic              RD,
    output logic              HLT,
    output logic [ADDR_W-1:0] MADDR,
    output logic [31:0]       MWDATA,
    output logic [3:0]        MBE,
    output logic              MWR,
    output logic              MRD,
    input  logic [31:0]       MRDATA,
    output logic [15:0]       STALLS,
    output logic [15:0]       STEPS
);
    typedef enum logic [2:0] {SEL, DISS, DWAIT, IISS, IWAIT, REL} state_t;
    localparam logic [2:0] LAST = 3'(MEM_LAT - 1);
    state_t            state_q;
    logic [2:0]        cnt_q;
    logic              hlt_q, mrd_q, mwr_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [31:0]       mwdata_q, idata_q, datai_q;
    logic [3:0]        mbe_q;
    logic [15:0]       stalls_q, stalls_d, steps_q, steps_d;
    logic              to_iiss, data_start, unused_bits;

    assign unused_bits = ^{IADDR[31:ADDR_W], DADDR[31:ADDR_W+2], DADDR[1:0]};
    assign data_start  = state_q == SEL && !HLTI && (WR || RD);
    assign to_iiss     = (state_q == SEL && !HLTI && !(WR || RD)) || (state_q == DISS && mwr_q) ||
                         (state_q == DWAIT && cnt_q == 3'd0);

    // step sequencer; memory strobes and halt are registered for the state being entered
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q  <= SEL;
            cnt_q    <= '0;
            hlt_q    <= 1'b1;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            maddr_q  <= '0;
            mbe_q    <= '0;
            mwdata_q <= '0;
            idata_q  <= '0;
            datai_q  <= '0;
        end else begin
            hlt_q    <= 1'b1;
            mrd_q    <= to_iiss || (data_start && !WR);
            mwr_q    <= data_start && WR;
            maddr_q  <= to_iiss ? IADDR[ADDR_W-1:0] : data_start ? DADDR[ADDR_W+1:2] : '0;
            mbe_q    <= to_iiss ? 4'hF : data_start ? (WR ? BE : 4'hF) : 4'h0;
            mwdata_q <= data_start && WR ? DATAO : '0;
            case (state_q)
                SEL:   if (!HLTI) state_q <= (WR || RD) ? DISS : IISS;
                DISS: begin
                    state_q <= mwr_q ? IISS : DWAIT;
                    cnt_q   <= LAST;
                end
                DWAIT: begin
                    if (cnt_q == 3'd0) begin
                        datai_q <= MRDATA;
                        state_q <= IISS;
                    end else cnt_q <= cnt_q - 3'd1;
                end
                IISS: begin
                    state_q <= IWAIT;
                    cnt_q   <= LAST;
                end
                IWAIT: begin
                    if (cnt_q == 3'd0) begin
                        idata_q <= MRDATA;
                        state_q <= REL;
                        hlt_q   <= 1'b0;
                    end else cnt_q <= cnt_q - 3'd1;
                end
                REL:     state_q <= SEL;
                default: state_q <= SEL;
            endcase
        end
    end

    // stall counter saturates, step counter wraps
    always_comb begin
        stalls_d = hlt_q && stalls_q != 16'hFFFF ? stalls_q + 16'd1 : stalls_q;
        steps_d  = state_q == REL ? steps_q + 16'd1 : steps_q;
    end

    // statistics registers
    always_ff @(posedge CLK) begin
        if (RES) begin
            stalls_q <= '0;
            steps_q  <= '0;
        end else begin
            stalls_q <= stalls_d;
            steps_q  <= steps_d;
        end
    end

    assign IDATA  = idata_q;
    assign DATAI  = datai_q;
    assign HLT    = hlt_q;
    assign MADDR  = maddr_q;
    assign MWDATA = mwdata_q;
    assign MBE    = mbe_q;
    assign MWR    = mwr_q;
    assign MRD    = mrd_q;
    assign STALLS = stalls_q;
    assign STEPS  = steps_q;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: random core steps checked against a transaction-level model of the arbiter
module tb_core_mem_arbiter;
    localparam int LAT = 2;
    localparam int AW  = 14;

    logic          CLK = 1'b0;
    logic          RES, HLTI, WR, RD, HLT, MWR, MRD;
    logic [31:0]   IADDR, DADDR, DATAO, IDATA, DATAI, MWDATA, MRDATA;
    logic [3:0]    BE, MBE;
    logic [AW-1:0] MADDR;
    logic [15:0]   STALLS, STEPS;

    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic [31:0]   ram [0:(1<<AW)-1];
    logic [31:0]   pipe [LAT];

    int          checks = 0, failures = 0;
    logic [31:0] exp_mem [0:63];
    logic [31:0] exp_idata, exp_datai;
    int          exp_stalls, exp_steps;
    logic [51:0] got_q[$];
    bit          idle_bad;

    core_mem_arbiter #(.MEM_LAT(LAT), .ADDR_W(AW)) dut (
        .CLK(CLK), .RES(RES), .HLTI(HLTI), .IADDR(IADDR), .IDATA(IDATA), .DADDR(DADDR),
        .DATAO(DATAO), .DATAI(DATAI), .BE(BE), .WR(WR), .RD(RD), .HLT(HLT), .MADDR(MADDR),
        .MWDATA(MWDATA), .MBE(MBE), .MWR(MWR), .MRD(MRD), .MRDATA(MRDATA),
        .STALLS(STALLS), .STEPS(STEPS)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // behavioural RAM: byte-enabled write, read data valid LAT cycles after MRD
    assign MRDATA = pipe[LAT-1];
    always @(posedge CLK) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (MWR) ram[MADDR] <= merge(ram[MADDR], MWDATA, MBE);
        pipe[0] <= MRD ? ram[MADDR] : 32'hBAD0BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        if (MRD) got_q.push_back({2'd1, MADDR, MBE, MWDATA});
        if (MWR) got_q.push_back({2'd2, MADDR, MBE, MWDATA});
        if ((MRD && MWR) || (!MWR && MWDATA != 0) || (!MRD && !MWR && (MADDR != 0 || MBE != 0))) idle_bad = 1;
    endtask

    function automatic int sat(input int v);
        return v > 65535 ? 65535 : v;
    endfunction

    // one core step, entered at the falling edge of its SEL cycle
    task automatic step(input bit wr, input bit rd, input int dw, input int iw);
        logic [51:0] exp_q[$];
        int len, cyc;
        IADDR = ($urandom & 32'hFFFF_C000) | 32'(iw);
        DADDR = ($urandom & 32'hFFFF_0003) | (32'(dw) << 2);
        DATAO = $urandom;
        BE    = 4'($urandom_range(0, 15));
        WR    = wr;
        RD    = rd;
        if (wr) begin
            exp_q.push_back({2'd2, 14'(dw), BE, DATAO});
            exp_mem[dw] = merge(exp_mem[dw], DATAO, BE);
            len = LAT + 4;
        end else if (rd) begin
            exp_q.push_back({2'd1, 14'(dw), 4'hF, 32'h0});
            exp_datai = exp_mem[dw];
            len = 2 * LAT + 4;
        end else len = LAT + 3;
        exp_q.push_back({2'd1, 14'(iw), 4'hF, 32'h0});
        exp_idata  = exp_mem[iw];
        exp_stalls = sat(exp_stalls + len - 1);
        got_q.delete();
        idle_bad = 0;
        cyc = 1;
        sample();
        while (HLT && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            sample();
        end
        check("step_len", 64'(cyc), 64'(len));
        check("n_events", 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) check("event", 64'(i < got_q.size() ? got_q[i] : 52'hF_FFFF_FFFF_FFFF), 64'(exp_q[i]));
        check("idle_values", 64'(idle_bad), 64'(0));
        check("idata", 64'(IDATA), 64'(exp_idata));
        check("datai", 64'(DATAI), 64'(exp_datai));
        check("stalls", 64'(STALLS), 64'(exp_stalls));
        check("steps", 64'(STEPS), 64'(exp_steps));
        exp_steps = (exp_steps + 1) & 16'hFFFF;
        @(negedge CLK);
    endtask

    // hold HLTI for n cycles in SEL; nothing may be issued
    task automatic hold(input int n);
        bit bad;
        bad  = 0;
        HLTI = 1;
        WR   = 0;
        RD   = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (MRD || MWR || !HLT || MADDR != 0 || MBE != 0) bad = 1;
        end
        exp_stalls = sat(exp_stalls + n);
        check("hlti_quiet", 64'(bad), 64'(0));
        check("hlti_stalls", 64'(STALLS), 64'(exp_stalls));
        HLTI = 0;
    endtask

    task automatic random_steps(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 3);
            step(k >= 2, k == 1 || k == 3, $urandom_range(0, 63), $urandom_range(0, 63));
        end
    endtask

    initial begin
        RES = 1; HLTI = 0; WR = 0; RD = 0; IADDR = 0; DADDR = 0; DATAO = 0; BE = 0;
        ld_en = 0; ld_addr = 0; ld_data = 0;
        exp_stalls = 0; exp_steps = 0; exp_idata = 0; exp_datai = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            ld_en   = 1;
            ld_addr = AW'(i);
            ld_data = i == 5 ? 32'h00100093 : i == 4 ? 32'hDEADBEEF : $urandom | 32'h1;
            exp_mem[i] = ld_data;
        end
        @(negedge CLK);
        ld_en = 0;
        check("rst_hlt", 64'(HLT), 64'(1));
        check("rst_mrd", 64'(MRD), 64'(0));
        check("rst_mwr", 64'(MWR), 64'(0));
        check("rst_maddr", 64'(MADDR), 64'(0));
        check("rst_mbe", 64'(MBE), 64'(0));
        check("rst_mwdata", 64'(MWDATA), 64'(0));
        check("rst_idata", 64'(IDATA), 64'(0));
        check("rst_datai", 64'(DATAI), 64'(0));
        check("rst_stalls", 64'(STALLS), 64'(0));
        check("rst_steps", 64'(STEPS), 64'(0));
        RES = 0;
        step(0, 0, 0, 5);
        step(0, 0, 0, 5);
        step(0, 1, 4, 6);
        step(1, 0, 4, 6);
        step(1, 1, 4, 6);
        random_steps(80);
        hold(10);
        step(0, 0, 0, 5);
        WR = 0; RD = 1; DADDR = 32'(7) << 2; IADDR = 32'd8;
        @(negedge CLK);
        @(negedge CLK);
        RES = 1;
        @(negedge CLK);
        check("dwait_rst_hlt", 64'(HLT), 64'(1));
        check("dwait_rst_mrd", 64'(MRD), 64'(0));
        check("dwait_rst_datai", 64'(DATAI), 64'(0));
        check("dwait_rst_idata", 64'(IDATA), 64'(0));
        check("dwait_rst_stalls", 64'(STALLS), 64'(0));
        check("dwait_rst_steps", 64'(STEPS), 64'(0));
        RES = 0; RD = 0;
        exp_stalls = 0; exp_steps = 0; exp_idata = 0; exp_datai = 0;
        step(0, 0, 0, 9);
        random_steps(80);
        hold(65534 - exp_stalls);
        hold(3);
        step(0, 0, 0, 5);
        step(0, 1, 4, 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Sequencer and arbiter that shares one single-port, fixed-latency synchronous memory between the core's instruction-fetch port and its data load/store port. It stretches each core step with the core's `HLT` input until that step's fetch, and any load or store, has completed. It sits between the core and the unified program/data RAM and presents registered `IDATA`/`DATAI` to the core. Two counters expose stall and step statistics.

## Interface
Parameters:
- `MEM_LAT`, 2: memory read latency in cycles, from the `MRD` cycle to valid `MRDATA`. Legal range 1..7.
- `ADDR_W`, 14: memory word-address width.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RES` in 1: reset, synchronous, active-high.
- `HLTI` in 1: external halt request (debug). Holds the arbiter in SEL.
- `IADDR` in 32: core fetch address. Word index; bits `[ADDR_W-1:0]` are used.
- `IDATA` out 32: fetched instruction, registered.
- `DADDR` in 32: core data byte address. Word address is `DADDR[ADDR_W+1:2]`.
- `DATAO` in 32: core store data.
- `DATAI` out 32: load data, registered.
- `BE` in 4: core byte enables.
- `WR` in 1: core store request.
- `RD` in 1: core load request.
- `HLT` out 1: halt to core. 0 only in REL.
- `MADDR` out ADDR_W: memory word address.
- `MWDATA` out 32: memory write data.
- `MBE` out 4: memory byte enables.
- `MWR` out 1: memory write strobe. One cycle; the write completes in that cycle.
- `MRD` out 1: memory read strobe. One cycle.
- `MRDATA` in 32: memory read data, valid exactly `MEM_LAT` cycles after `MRD`.
- `STALLS` out 16: count of cycles with `HLT`=1 outside reset. Saturates at 0xFFFF.
- `STEPS` out 16: count of REL cycles. Wraps.

## Operation
- States: SEL, DISS, DWAIT, IISS, IWAIT, REL. Wait counter is 3 bits.
- SEL: no strobes.
  - `HLTI`=1: stay in SEL.
  - Else `WR|RD`: go to DISS.
  - Else: go to IISS.
- DISS: `MADDR`=`DADDR[ADDR_W+1:2]`.
  - `WR`=1: `MWR`=1, `MWDATA`=`DATAO`, `MBE`=`BE`, then go to IISS. `WR` has priority over simultaneous `RD`; in that case `DATAI` is unchanged.
  - Else (read): `MRD`=1, `MBE`=4'b1111, then go to DWAIT.
- DWAIT: lasts `MEM_LAT` cycles. On the last cycle, `DATAI`<=`MRDATA`, then go to IISS.
- IISS: `MRD`=1, `MADDR`=`IADDR[ADDR_W-1:0]`, `MBE`=4'b1111. Then go to IWAIT.
- IWAIT: lasts `MEM_LAT` cycles. On the last cycle, `IDATA`<=`MRDATA`, then go to REL.
- REL: `HLT`=0 for exactly one cycle; the core advances on that edge. `STEPS`+1. Then go to SEL.
- Core inputs are sampled only in SEL/DISS/IISS. The core holds them stable while `HLT`=1.
- `HLTI` is sampled only in SEL. An access already in flight always runs through REL.
- Idle values: `MWDATA`=0 whenever `MWR`=0; `MADDR` and `MBE`=0 in SEL, DWAIT, IWAIT and REL.

## Timing
- Reset (`RES`=1 at an edge): state=SEL, `HLT`=1, `MRD`=`MWR`=0, `MADDR`=0, `MBE`=0, `MWDATA`=0, `IDATA`=`DATAI`=0, `STALLS`=`STEPS`=0, wait counter=0.
- Reset mid-operation aborts the access. `MRDATA` returning later is ignored. No partial write occurs after the reset edge.
- `HLT` is 1 throughout reset, so the core resets while halted.
- All outputs are registered: no combinational path from core inputs to memory strobes or to `HLT`.
- Core step length, counted from SEL to REL inclusive:
  - fetch only: `MEM_LAT`+3
  - store: `MEM_LAT`+4
  - load: 2·`MEM_LAT`+4
- `STALLS` does not increment while `RES`=1. It holds at 0xFFFF once saturated.
- `STEPS` wraps from 0xFFFF to 0.

## Test plan
All scenarios use `MEM_LAT`=2.
- Reset: hold `RES`=1 for 2 cycles → `HLT`=1, `MRD`=`MWR`=0, `IDATA`=`DATAI`=0, `STALLS`=`STEPS`=0, state=SEL.
- Fetch only: `IADDR`=5, mem[5]=0x00100093 → `MRD`=1 with `MADDR`=5 in cycle 1. `HLT`=0 in cycle 4 with `IDATA`=0x00100093. Steps repeat every 5 cycles; `STALLS` grows by 4 per step.
- Load: `RD`=1, `DADDR`=0x10, mem[4]=0xDEADBEEF, `IADDR`=6 → `MRD` with `MADDR`=4 and `MBE`=1111, then `MRD` with `MADDR`=6. `HLT`=0 on cycle 7; `DATAI`=0xDEADBEEF.
- Store: `WR`=1, `BE`=0100, `DADDR`=0x12, `DATAO`=0x00AB0000 → one cycle with `MWR`=1, `MADDR`=4, `MBE`=0100, `MWDATA`=0x00AB0000. Step is 6 cycles. `WR`+`RD` together behave identically, with `DATAI` unchanged.
- Reset in DWAIT: assert `RES` during the first DWAIT cycle → next cycle state=SEL and `DATAI`=0. The stale `MRDATA` is never captured. The following step fetches normally.
- `HLTI` held for 10 cycles in SEL → no strobes, `HLT`=1, `STALLS`+10. After release, a normal 5-cycle fetch step follows. Preloaded `STALLS`=0xFFFE saturates at 0xFFFF.
